uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
- Shares the single UART transmitter among NUM_REQ requesters, e.g. the command responder, the capture-dump engine and the debug port.
- Selects a requester by round-robin and hands its byte to the transmitter.
- Issues the one-cycle transmit strobe and waits for the transmitter's done flag to rise.
- Acknowledges each byte and keeps the grant until the requester marks its last byte, so multi-byte messages are never interleaved.

Parameters:
NUM_REQ, 3, number of requesters (2..8).
TIMEOUT_CYC, 1024, cycles to wait for tx_done rising before aborting a byte. This exceeds one 10-bit frame at 44 clk/bit.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester byte-valid; held with data until that requester's ack
req_data  input  8*NUM_REQ  byte of requester i on bits [8i+7:8i]
req_last  input  NUM_REQ  byte presented is the final byte of the message
tx_done  input  1  transmitter done flag; level, cleared by trmt
trmt  output  1  one-cycle transmit strobe to the transmitter
tx_data  output  8  byte to the transmitter, registered
gnt  output  NUM_REQ  one-hot current owner; 0 when idle
ack  output  NUM_REQ  one-cycle pulse: owner's byte finished or aborted
busy  output  1  high in every state except IDLE
err  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, rst_n low): state IDLE; trmt=0, tx_data=8'h00, gnt=0, ack=0, busy=0, err=0; rr pointer=0; done_q=0; timeout counter=0.
- done_q: tx_done registered every cycle. done_rise = tx_done & ~done_q. This is the only completion indication.
- Transmitter constraint: tx_done stays high after a frame and resets low. Its level is never treated as completion.
- IDLE:
  - If any req bit is set, pick the first set bit scanning ptr, ptr+1, … wrapping at NUM_REQ.
  - Register gnt, tx_data = selected byte and last_q = selected req_last. Go to SEND.
- SEND: trmt=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On done_rise: go to ACK.
  - Else if counter reaches TIMEOUT_CYC-1: pulse err, force last_q=1, go to ACK.
  - done_rise in the same cycle as timeout counts as success; no err.
- ACK:
  - ack[owner]=1 for one cycle.
  - If last_q=1: clear gnt, ptr = owner+1 (wraps to 0 after NUM_REQ-1), go to IDLE.
  - Else go to NEXT.
- NEXT (requester updates req and data after ack):
  - If req[owner]=1: latch req_data and req_last of owner, go to SEND.
  - If req[owner]=0: release as in ACK with last, go to IDLE.
  - Other requesters are ignored while a grant is held.
- Byte-to-byte latency within a message: ACK→NEXT→SEND, so trmt is 3 cycles after done_rise.
- First trmt is 1 cycle after IDLE sees req.
- tx_data is stable from SEND until the next latch; trmt is never asserted outside SEND.
- Simultaneous requests resolve strictly by ptr order. After release, the owner has lowest priority. A continuously requesting set gets one message each in rotation.
- A requester dropping req mid-byte (WAIT) does not abort the byte; the byte completes and is acked.
- Reset mid-frame: outputs return to reset values immediately. The transmitter is reset by the same rst_n.

Test Plan:
- Single byte: req=3'b001, data0=8'hA5, last0=1. Expect trmt 1 cycle later with tx_data=8'hA5. Model done_rise 440 cycles later. Expect ack=3'b001 one cycle after, gnt→0, ptr=1.
- Message lock: req0 sends 3 bytes 8'h11,8'h22,8'h33 (last on 3rd) while req2 is asserted throughout. Expect three trmt pulses all with gnt=3'b001, and each trmt 3 cycles after the previous done_rise. Then req2 is granted.
- Round-robin: req=3'b111 continuously, all single-byte (last=1), run 6 bytes. Grant order 0,1,2,0,1,2.
- Stale done level: tx_done held high from reset, req1 byte 8'h5A. No ack until tx_done falls after trmt and rises again.
- Timeout: tx_done held low after trmt, req0 message not last. Expect err and ack0 together at cycle TIMEOUT_CYC after SEND, grant released, IDLE.
- Reset mid-WAIT: assert rst_n low. trmt, gnt, ack, busy go to 0 asynchronously. After release, the pending req is re-arbitrated from ptr=0.

Source files
------------

// File: rtl/uart_tx_arb_if.sv
// Requester/transmitter-side signal bundle for the shared UART transmit arbiter.
interface uart_tx_arb_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic                 tx_done;
    logic                 trmt;
    logic [7:0]           tx_data;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   ack;
    logic                 busy;
    logic                 err;

    modport master (
        output req, req_data, req_last, tx_done,
        input  trmt, tx_data, gnt, ack, busy, err
    );

    modport slave (
        input  req, req_data, req_last, tx_done,
        output trmt, tx_data, gnt, ack, busy, err
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters,
// holding the grant for a whole multi-byte message.
module uart_tx_arb #(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic          clk,
    input logic          rst_n,
    uart_tx_arb_if.slave bus
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT, ACK, NEXT} state_t;

    state_t             state, state_nxt;
    logic [IW-1:0]      ptr, owner, sel_idx;
    logic               sel_found;
    logic [NUM_REQ-1:0] gnt_q;
    logic [7:0]         tx_data_q;
    logic               last_q, done_q, err_q;
    logic [CW-1:0]      cnt, cnt_inc;
    logic               done_rise, latch_new, latch_own, release_own, timeout_hit;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int unsigned b);
        int unsigned s;
        s = 32'(a) + b;
        if (s >= unsigned'(NUM_REQ)) s = s - unsigned'(NUM_REQ);
        return IW'(s);
    endfunction

    assign done_rise = bus.tx_done & ~done_q;
    assign cnt_inc   = cnt + 1'b1;

    // First requesting index scanning from ptr upward with wrap.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < unsigned'(NUM_REQ); i++) begin
            if (!sel_found && bus.req[wrap_add(ptr, i)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_add(ptr, i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        latch_new   = 1'b0;
        latch_own   = 1'b0;
        release_own = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: if (sel_found) begin
                latch_new = 1'b1;
                state_nxt = SEND;
            end
            SEND: state_nxt = WAIT;
            WAIT: begin
                // A rise coinciding with the timeout still counts as success.
                if (done_rise) begin
                    state_nxt = ACK;
                end else if (cnt_inc == CW'(TIMEOUT_CYC - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ACK;
                end
            end
            ACK: begin
                if (last_q) begin
                    release_own = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (bus.req[owner]) begin
                    latch_own = 1'b1;
                    state_nxt = SEND;
                end else begin
                    release_own = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            owner     <= '0;
            gnt_q     <= '0;
            tx_data_q <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt       <= '0;
        end else begin
            done_q <= bus.tx_done;
            err_q  <= timeout_hit;
            if (state == SEND)      cnt <= '0;
            else if (state == WAIT) cnt <= cnt_inc;
            if (latch_new) begin
                gnt_q     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
                owner     <= sel_idx;
                tx_data_q <= bus.req_data[{sel_idx, 3'b000} +: 8];
                last_q    <= bus.req_last[sel_idx];
            end else if (latch_own) begin
                tx_data_q <= bus.req_data[{owner, 3'b000} +: 8];
                last_q    <= bus.req_last[owner];
            end
            // An aborted byte ends the message so the grant is not held forever.
            if (timeout_hit) last_q <= 1'b1;
            if (release_own) begin
                gnt_q <= '0;
                ptr   <= wrap_add(owner, 1);
            end
        end
    end

    assign bus.trmt    = (state == SEND);
    assign bus.ack     = (state == ACK) ? gnt_q : '0;
    assign bus.busy    = (state != IDLE);
    assign bus.gnt     = gnt_q;
    assign bus.tx_data = tx_data_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a behavioural transmitter driving tx_done.
module tb_uart_tx_arb;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_bad;
    int   frame_cyc;
    int   clr_dly;
    bit   xmit_on;

    uart_tx_arb_if #(.NUM_REQ(3)) bif ();

    uart_tx_arb #(.NUM_REQ(3), .TIMEOUT_CYC(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Transmitter: clears done clr_dly cycles after trmt, raises it frame_cyc later.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst_n && bif.trmt) begin
                for (int k = 0; k < clr_dly && rst_n; k++) begin @(posedge clk); #1; end
                if (rst_n) begin
                    bif.tx_done = 1'b0;
                    if (xmit_on) begin
                        for (int k = 0; k < frame_cyc && rst_n; k++) begin @(posedge clk); #1; end
                        if (rst_n) bif.tx_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic do_reset(input logic done_lvl);
        @(negedge clk);
        rst_n        = 1'b0;
        bif.req      = '0;
        bif.req_last = '0;
        bif.req_data = '0;
        bif.tx_done  = done_lvl;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_trmt(input string tag, input int exp_lat);
        int  t;
        bit  seen;
        t    = 0;
        seen = 1'b0;
        while (!seen && t < 60) begin
            @(negedge clk);
            t++;
            if (bif.trmt) seen = 1'b1;
        end
        chk({tag, "_trmt_seen"}, 32'(seen), 1);
        chk({tag, "_lat"}, t, exp_lat);
    endtask

    task automatic wait_ack(input string tag, input logic [2:0] exp_gnt);
        int   n;
        int   rise_at;
        logic prev;
        prev    = bif.tx_done;
        rise_at = -1;
        @(negedge clk);
        n = 1;
        chk({tag, "_trmt_1cyc"}, 32'(bif.trmt), 0);
        while (n < 3000) begin
            if (bif.ack != 3'b000) break;
            if (rise_at < 0 && bif.tx_done && !prev) rise_at = n;
            prev = bif.tx_done;
            @(negedge clk);
            n++;
        end
        chk({tag, "_ack"}, 32'(bif.ack), 32'(exp_gnt));
        chk({tag, "_err"}, 32'(bif.err), 0);
        chk({tag, "_ack_after_rise"}, n - rise_at, 1);
    endtask

    task automatic xfer(input string tag, input logic [2:0] exp_gnt, input logic [7:0] exp_data,
                        input int exp_lat);
        wait_trmt(tag, exp_lat);
        chk({tag, "_gnt"}, 32'(bif.gnt), 32'(exp_gnt));
        chk({tag, "_data"}, 32'(bif.tx_data), 32'(exp_data));
        wait_ack(tag, exp_gnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish exp finish");
        $fatal(1);
    end

    initial begin
        int n;
        n_chk     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        frame_cyc = 440;
        clr_dly   = 0;
        xmit_on   = 1'b1;

        do_reset(1'b0);
        chk("rst_trmt", 32'(bif.trmt), 0);
        chk("rst_gnt", 32'(bif.gnt), 0);
        chk("rst_ack", 32'(bif.ack), 0);
        chk("rst_busy", 32'(bif.busy), 0);
        chk("rst_err", 32'(bif.err), 0);
        chk("rst_data", 32'(bif.tx_data), 0);

        // Single byte, then ptr=1 makes req1 win over req0.
        bif.req_data = 24'h0000A5;
        bif.req_last = 3'b001;
        bif.req      = 3'b001;
        xfer("single", 3'b001, 8'hA5, 1);
        bif.req = 3'b000;
        @(negedge clk);
        chk("single_gnt_rel", 32'(bif.gnt), 0);
        chk("single_idle", 32'(bif.busy), 0);
        frame_cyc    = 10;
        bif.req_data = 24'h000201;
        bif.req_last = 3'b011;
        bif.req      = 3'b011;
        xfer("ptr1", 3'b010, 8'h02, 1);
        bif.req = 3'b001;
        xfer("ptr1_r0", 3'b001, 8'h01, 2);
        bif.req = 3'b000;

        // Message lock against a waiting req2.
        do_reset(1'b0);
        frame_cyc    = 20;
        bif.req_data = 24'hC30011;
        bif.req_last = 3'b100;
        bif.req      = 3'b101;
        xfer("lock1", 3'b001, 8'h11, 1);
        bif.req_data[7:0] = 8'h22;
        xfer("lock2", 3'b001, 8'h22, 2);
        bif.req_data[7:0] = 8'h33;
        bif.req_last      = 3'b101;
        xfer("lock3", 3'b001, 8'h33, 2);
        bif.req = 3'b100;
        xfer("lock_r2", 3'b100, 8'hC3, 2);
        bif.req = 3'b000;

        // Round-robin across three continuous single-byte requesters.
        do_reset(1'b0);
        frame_cyc    = 8;
        bif.req_data = 24'h323130;
        bif.req_last = 3'b111;
        bif.req      = 3'b111;
        for (int k = 0; k < 6; k++) begin
            xfer($sformatf("rr%0d", k), 3'(1 << (k % 3)), 8'(8'h30 + k % 3), (k == 0) ? 1 : 2);
        end
        bif.req = 3'b000;

        // Stale done level: high from reset, cleared late by the transmitter.
        do_reset(1'b1);
        clr_dly      = 3;
        frame_cyc    = 12;
        bif.req_data = 24'h005A00;
        bif.req_last = 3'b010;
        bif.req      = 3'b010;
        xfer("stale", 3'b010, 8'h5A, 1);
        bif.req = 3'b000;
        clr_dly = 0;

        // Timeout on a non-last byte.
        do_reset(1'b0);
        xmit_on      = 1'b0;
        bif.req_data = 24'h000077;
        bif.req_last = 3'b000;
        bif.req      = 3'b001;
        wait_trmt("to", 1);
        n = 0;
        while (bif.ack == 3'b000 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, 1024);
        chk("to_err", 32'(bif.err), 1);
        chk("to_ack", 32'(bif.ack), 32'(3'b001));
        @(negedge clk);
        chk("to_release_gnt", 32'(bif.gnt), 0);
        chk("to_release_idle", 32'(bif.busy), 0);
        chk("to_err_pulse", 32'(bif.err), 0);
        bif.req = 3'b000;
        xmit_on = 1'b1;

        // Reset during WAIT, after ptr has moved to 1.
        do_reset(1'b0);
        frame_cyc    = 50;
        bif.req_data = 24'h009E4C;
        bif.req_last = 3'b011;
        bif.req      = 3'b001;
        xfer("pre", 3'b001, 8'h4C, 1);
        bif.req = 3'b011;
        wait_trmt("mid", 2);
        chk("mid_gnt", 32'(bif.gnt), 32'(3'b010));
        repeat (5) @(negedge clk);
        chk("mid_busy", 32'(bif.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_trmt", 32'(bif.trmt), 0);
        chk("arst_gnt", 32'(bif.gnt), 0);
        chk("arst_ack", 32'(bif.ack), 0);
        chk("arst_busy", 32'(bif.busy), 0);
        chk("arst_data", 32'(bif.tx_data), 0);
        bif.tx_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xfer("rearb", 3'b001, 8'h4C, 1);
        bif.req = 3'b010;
        xfer("rearb_r1", 3'b010, 8'h9E, 2);
        bif.req = 3'b000;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
